// File: rtl/d3s_nco_pkg.sv
// Shared constants and types for the D3S multi-channel NCO.
// Register offsets are byte offsets within a channel's 16-byte window.
package d3s_nco_pkg;

    localparam logic [3:0] c_NCO_RFREQL     = 4'h0;
    localparam logic [3:0] c_NCO_RFREQH     = 4'h4;
    localparam logic [3:0] c_NCO_PHASE_INIT = 4'h8;
    localparam logic [3:0] c_NCO_CTRL       = 4'hC;

    localparam int c_NCO_CTRL_ENABLE  = 0;
    localparam int c_NCO_CTRL_SW_SYNC = 1;

    // Sized for the widest accumulator; unused FTW bits are kept at zero.
    typedef struct packed {
        logic [63:0] ftw_shadow;
        logic [31:0] phase_init;
        logic        enable;
    } t_nco_ch_regs;

endpackage

// File: rtl/d3s_nco_channel.sv
// One phase accumulator with atomic FTW commit, sync reload and wrap tick.
// With D3S_NCO_SNAPSHOT_EN defined it also exports the top 32 accumulator bits.
module d3s_nco_channel
    import d3s_nco_pkg::*;
#(
    parameter int g_acc_width = 48,
    parameter int g_out_width = 16
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_a_i,
    input  logic                   enable_i,
    input  logic                   sync_i,
    input  logic                   ftw_commit_i,
    input  logic [g_acc_width-1:0] ftw_i,
    input  logic [31:0]            phase_init_i,
`ifdef D3S_NCO_SNAPSHOT_EN
    output logic [31:0]            acc_hi_o,
`endif
    output logic [g_out_width-1:0] phase_o,
    output logic                   tick_o
);

    logic [g_acc_width-1:0] acc;
    logic [g_acc_width-1:0] ftw;
    logic [g_acc_width:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, ftw};

    // NOTE: all state here uses <= so every register samples pre-edge values;
    // acc therefore adds the old FTW on the same edge that commits a new one.
    always_ff @(posedge clk_sys_i or posedge rst_a_i) begin
        if (rst_a_i) begin
            acc     <= '0;
            ftw     <= '0;
            phase_o <= '0;
            tick_o  <= 1'b0;
        end else begin
            phase_o <= acc[g_acc_width-1 -: g_out_width];
            tick_o  <= 1'b0;
            if (ftw_commit_i)
                ftw <= ftw_i;
            if (enable_i) begin
                if (sync_i) begin
                    acc <= {phase_init_i, {(g_acc_width-32){1'b0}}};
                end else begin
                    acc    <= sum[g_acc_width-1:0];
                    tick_o <= sum[g_acc_width];
                end
            end
        end
    end

`ifdef D3S_NCO_SNAPSHOT_EN
    assign acc_hi_o = acc[g_acc_width-1 -: 32];
`endif

endmodule

// File: rtl/d3s_nco_multi.sv
// Multi-channel NCO bank with register-bus decoder (125 MHz system domain).
// Define D3S_NCO_SNAPSHOT_EN to add snap_p_i and the capture registers at 0x80.
module d3s_nco_multi
    import d3s_nco_pkg::*;
#(
    parameter int g_num_channels = 2,
    parameter int g_acc_width    = 48,
    parameter int g_out_width    = 16
) (
    input  logic                                clk_sys_i,
    input  logic                                rst_a_i,
    input  logic [7:0]                          reg_adr_i,
    input  logic [31:0]                         reg_dat_i,
    input  logic                                reg_we_i,
    input  logic                                reg_stb_i,
    output logic [31:0]                         reg_dat_o,
    output logic                                reg_ack_o,
    input  logic                                sync_p_i,
`ifdef D3S_NCO_SNAPSHOT_EN
    input  logic                                snap_p_i,
`endif
    output logic [g_num_channels*g_out_width-1:0] phase_o,
    output logic [g_num_channels-1:0]           tick_o
);

    localparam int          c_hi_width = g_acc_width - 32;
    localparam logic [31:0] c_hi_mask  = 32'hFFFF_FFFF >> (64 - g_acc_width);

    logic         accept;
    logic         ch_region;
    logic         wr_en;
    logic [2:0]   sel_ch;
    logic [3:0]   sel_reg;
    logic [31:0]  rd_data;
    logic         unused_adr;
    t_nco_ch_regs regs [g_num_channels];

    assign accept     = reg_stb_i & ~reg_ack_o;
    assign ch_region  = ~reg_adr_i[7];
    assign wr_en      = accept & reg_we_i & ch_region;
    assign sel_ch     = reg_adr_i[6:4];
    assign sel_reg    = {reg_adr_i[3:2], 2'b00};
    assign unused_adr = ^reg_adr_i[1:0];

    // NOTE: the register file is small and must read back 0 after reset, so
    // every entry is reset explicitly rather than treated as uninitialised RAM.
    always_ff @(posedge clk_sys_i or posedge rst_a_i) begin
        if (rst_a_i) begin
            for (int i = 0; i < g_num_channels; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < g_num_channels; i++) begin
                if (sel_ch == 3'(i)) begin
                    case (sel_reg)
                        c_NCO_RFREQL:     regs[i].ftw_shadow[31:0]  <= reg_dat_i;
                        c_NCO_RFREQH:     regs[i].ftw_shadow[63:32] <= reg_dat_i & c_hi_mask;
                        c_NCO_PHASE_INIT: regs[i].phase_init        <= reg_dat_i;
                        c_NCO_CTRL:       regs[i].enable            <= reg_dat_i[c_NCO_CTRL_ENABLE];
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef D3S_NCO_SNAPSHOT_EN
    logic [31:0] acc_hi [g_num_channels];
    logic [31:0] snap   [g_num_channels];

    always_ff @(posedge clk_sys_i or posedge rst_a_i) begin
        if (rst_a_i) begin
            for (int i = 0; i < g_num_channels; i++)
                snap[i] <= '0;
        end else if (snap_p_i) begin
            for (int i = 0; i < g_num_channels; i++)
                snap[i] <= acc_hi[i];
        end
    end
`endif

    for (genvar i = 0; i < g_num_channels; i++) begin : g_ch
        logic sel;
        logic commit;
        logic sw_sync;

        assign sel     = wr_en & (sel_ch == 3'(i));
        assign commit  = sel & (sel_reg == c_NCO_RFREQH);
        assign sw_sync = sel & (sel_reg == c_NCO_CTRL) & reg_dat_i[c_NCO_CTRL_SW_SYNC];

        // The commit value pairs the incoming high word with the stored low word.
        d3s_nco_channel #(
            .g_acc_width (g_acc_width),
            .g_out_width (g_out_width)
        ) u_channel (
            .clk_sys_i    (clk_sys_i),
            .rst_a_i      (rst_a_i),
            .enable_i     (regs[i].enable),
            .sync_i       (sync_p_i | sw_sync),
            .ftw_commit_i (commit),
            .ftw_i        ({reg_dat_i[c_hi_width-1:0], regs[i].ftw_shadow[31:0]}),
            .phase_init_i (regs[i].phase_init),
`ifdef D3S_NCO_SNAPSHOT_EN
            .acc_hi_o     (acc_hi[i]),
`endif
            .phase_o      (phase_o[i*g_out_width +: g_out_width]),
            .tick_o       (tick_o[i])
        );
    end

    // NOTE: rd_data gets a default before any branch so no latch is inferred.
    always_comb begin
        rd_data = '0;
        if (ch_region) begin
            for (int i = 0; i < g_num_channels; i++) begin
                if (sel_ch == 3'(i)) begin
                    case (sel_reg)
                        c_NCO_RFREQL:     rd_data = regs[i].ftw_shadow[31:0];
                        c_NCO_RFREQH:     rd_data = regs[i].ftw_shadow[63:32];
                        c_NCO_PHASE_INIT: rd_data = regs[i].phase_init;
                        c_NCO_CTRL:       rd_data[c_NCO_CTRL_ENABLE] = regs[i].enable;
                        default: ;
                    endcase
                end
            end
        end
`ifdef D3S_NCO_SNAPSHOT_EN
        else begin
            for (int i = 0; i < g_num_channels; i++)
                if (reg_adr_i[6:2] == 5'(i))
                    rd_data = snap[i];
        end
`endif
    end

    always_ff @(posedge clk_sys_i or posedge rst_a_i) begin
        if (rst_a_i) begin
            reg_ack_o <= 1'b0;
            reg_dat_o <= '0;
        end else begin
            reg_ack_o <= accept;
            reg_dat_o <= (accept & ~reg_we_i) ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_d3s_nco_multi.sv
// Self-checking bench for d3s_nco_multi: behavioural model plus directed literals.
module tb_d3s_nco_multi;

    localparam int N   = 2;
    localparam int W   = 48;
    localparam int OUT = 16;
    localparam longint unsigned MOD = 64'd1 << W;

    logic        clk_125m = 1'b0;
    logic        rst_a    = 1'b1;
    logic [7:0]  adr      = '0;
    logic [31:0] wdat     = '0;
    logic        we       = 1'b0;
    logic        stb      = 1'b0;
    logic        sync     = 1'b0;

    logic [31:0]      rdat;
    logic             ack;
    logic [N*OUT-1:0] phase;
    logic [N-1:0]     tick;

    int errors = 0;
    int checks = 0;

    d3s_nco_multi #(
        .g_num_channels (N),
        .g_acc_width    (W),
        .g_out_width    (OUT)
    ) dut (
        .clk_sys_i (clk_125m),
        .rst_a_i   (rst_a),
        .reg_adr_i (adr),
        .reg_dat_i (wdat),
        .reg_we_i  (we),
        .reg_stb_i (stb),
        .reg_dat_o (rdat),
        .reg_ack_o (ack),
        .sync_p_i  (sync),
`ifdef D3S_NCO_SNAPSHOT_EN
        .snap_p_i  (1'b0),
`endif
        .phase_o   (phase),
        .tick_o    (tick)
    );

    always #4 clk_125m = ~clk_125m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint unsigned m_acc    [N];
    longint unsigned m_ftw    [N];
    longint unsigned m_shadow [N];
    logic [31:0]     m_init   [N];
    bit              m_en     [N];
    logic [OUT-1:0]  m_phase  [N];
    bit              m_tick   [N];
    bit              m_ack;
    logic [31:0]     m_rdat;

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int c;
        c = int'(a[6:4]);
        if (a[7] || c >= N) return 32'h0;
        case (a[3:2])
            2'd0:    return m_shadow[c][31:0];
            2'd1:    return m_shadow[c][63:32];
            2'd2:    return m_init[c];
            default: return {31'h0, m_en[c]};
        endcase
    endfunction

    always @(posedge clk_125m or posedge rst_a) begin : model
        bit acc_ok, wr, sw;
        int c, r;
        longint unsigned sum;
        if (rst_a) begin
            for (int k = 0; k < N; k++) begin
                m_acc[k] = 0; m_ftw[k] = 0; m_shadow[k] = 0; m_init[k] = 0;
                m_en[k] = 0; m_phase[k] = 0; m_tick[k] = 0;
            end
            m_ack  = 0;
            m_rdat = 0;
        end else begin
            acc_ok = stb && !m_ack;
            wr     = acc_ok && we && !adr[7];
            c      = int'(adr[6:4]);
            r      = int'(adr[3:2]);
            m_rdat = (acc_ok && !we) ? m_read(adr) : 32'h0;
            m_ack  = acc_ok;
            for (int k = 0; k < N; k++) begin
                m_phase[k] = OUT'(m_acc[k] >> (W - OUT));
                m_tick[k]  = 0;
                sw = wr && c == k && r == 3 && wdat[1];
                if (m_en[k]) begin
                    if (sync || sw) begin
                        m_acc[k] = 64'(m_init[k]) << (W - 32);
                    end else begin
                        sum        = m_acc[k] + m_ftw[k];
                        m_tick[k]  = sum >= MOD;
                        m_acc[k]   = sum % MOD;
                    end
                end
            end
            if (wr && c < N) begin
                case (r)
                    0: m_shadow[c] = (m_shadow[c] & 64'hFFFF_FFFF_0000_0000) | 64'(wdat);
                    1: begin
                        m_shadow[c] = ((64'(wdat) << 32) | (m_shadow[c] & 64'hFFFF_FFFF)) % MOD;
                        m_ftw[c]    = m_shadow[c];
                    end
                    2: m_init[c] = wdat;
                    default: m_en[c] = wdat[0];
                endcase
            end
        end
    end

    always @(negedge clk_125m) begin : compare
        if (!rst_a) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("phase ch%0d", k), 64'(phase[k*OUT +: OUT]), 64'(m_phase[k]));
                check($sformatf("tick ch%0d", k), 64'(tick[k]), 64'(m_tick[k]));
            end
            check("ack", 64'(ack), 64'(m_ack));
            if (m_ack) check("rdata", 64'(rdat), 64'(m_rdat));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk_125m);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk_125m); #1;
        adr = a; wdat = d; we = 1'b1; stb = 1'b1;
        @(posedge clk_125m); #1;
        stb = 1'b0; we = 1'b0;
        check("write ack latency", 64'(ack), 64'd1);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(posedge clk_125m); #1;
        adr = a; we = 1'b0; stb = 1'b1;
        @(posedge clk_125m); #1;
        stb = 1'b0;
        check("read ack latency", 64'(ack), 64'd1);
        d = rdat;
    endtask

    logic [31:0] d;
    logic [15:0] ph [8];
    logic        tk [8];
    logic [15:0] nxt;
    logic [15:0] p1;
    int          nticks;

    initial begin
        idle(3);
        rst_a = 1'b0;

        // all registers read 0 after reset
        for (int a = 0; a < 8; a++) begin
            bus_read(8'(a * 4), d);
            check("reset read", 64'(d), 64'h0);
        end

        // RFREQL alone must not change the active FTW
        bus_write(8'h0C, 32'h1);
        bus_write(8'h00, 32'h1000_0000);
        idle(20);
        check("frozen phase", 64'(phase[15:0]), 64'h0);
        bus_write(8'h04, 32'h0);
        idle(40);

        // wrap every 4th cycle, sync to 0 first via SW_SYNC
        bus_write(8'h00, 32'h0);
        bus_write(8'h04, 32'h4000);
        bus_write(8'h08, 32'h0);
        bus_write(8'h0C, 32'h3);
        @(negedge clk_125m);
        for (int s = 0; s < 8; s++) begin
            @(negedge clk_125m);
            ph[s] = phase[15:0];
            tk[s] = tick[0];
        end
        check("wrap start", 64'(ph[0]), 64'h0);
        nticks = 0;
        for (int s = 0; s < 8; s++) begin
            if (s > 0) begin
                nxt = ph[s-1] + 16'h4000;
                check("wrap step", 64'(ph[s]), 64'(nxt));
            end
            if (tk[s]) begin
                nticks++;
                check("tick on 0xC000", 64'(ph[s]), 64'hC000);
            end
        end
        check("tick count", 64'(nticks), 64'd2);
        bus_read(8'h0C, d);
        check("ctrl after sw_sync", 64'(d), 64'h1);

        // sync: ch0 loads init, disabled ch1 holds
        bus_write(8'h1C, 32'h1);
        bus_write(8'h10, 32'h1234_5678);
        bus_write(8'h14, 32'h77);
        idle(5);
        bus_write(8'h1C, 32'h0);
        bus_write(8'h08, 32'h8000_0000);
        idle(3);
        p1 = phase[31:16];
        @(posedge clk_125m); #1 sync = 1'b1;
        @(posedge clk_125m); #1 sync = 1'b0;
        @(negedge clk_125m);
        check("no tick on sync", 64'(tick[0]), 64'h0);
        @(negedge clk_125m);
        check("sync phase", 64'(phase[15:0]), 64'h8000);
        check("disabled ch hold", 64'(phase[31:16]), 64'(p1));

        // sync on the same edge as an RFREQH commit
        bus_write(8'h08, 32'h1234_0000);
        @(posedge clk_125m); #1;
        adr = 8'h04; wdat = 32'h0100; we = 1'b1; stb = 1'b1; sync = 1'b1;
        @(posedge clk_125m); #1;
        stb = 1'b0; we = 1'b0; sync = 1'b0;
        @(negedge clk_125m);
        @(negedge clk_125m);
        check("simul init", 64'(phase[15:0]), 64'h1234);
        @(negedge clk_125m);
        check("simul new ftw", 64'(phase[15:0]), 64'h1334);

        // out-of-range channel and unmapped snapshot window read 0
        bus_read(8'h70, d);
        check("ch7 read", 64'(d), 64'h0);
        bus_read(8'h84, d);
        check("0x84 read", 64'(d), 64'h0);

        // randomized traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk_125m); #1;
            stb  = ($urandom_range(0, 3) == 0);
            we   = $urandom_range(0, 1) == 1;
            wdat = $urandom;
            sync = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0)
                adr = 8'($urandom);
            else
                adr = {1'b0, 3'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'b00};
        end
        @(posedge clk_125m); #1;
        stb = 1'b0; we = 1'b0; sync = 1'b0;
        idle(3);

        // asynchronous reset while running with an ack pending
        bus_write(8'h00, 32'h0);
        bus_write(8'h04, 32'h2000);
        bus_write(8'h0C, 32'h1);
        idle(3);
        @(posedge clk_125m); #1;
        adr = 8'h00; we = 1'b0; stb = 1'b1;
        @(posedge clk_125m); #1;
        stb = 1'b0;
        check("ack before reset", 64'(ack), 64'd1);
        #2 rst_a = 1'b1;
        #1;
        check("reset phase", 64'(phase), 64'h0);
        check("reset tick", 64'(tick), 64'h0);
        check("reset ack", 64'(ack), 64'h0);
        idle(3);
        rst_a = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus_read(8'(a * 4), d);
            check("post-reset read", 64'(d), 64'h0);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/d3s_nco_multi.md
Name: d3s_nco_multi

Overview:
- Multi-channel numerically controlled oscillator (phase accumulator bank) for the D3S ADC/RF path on the SVEC node.
- Successor to the single-channel RFREQL/RFREQH tuning block, generalised in channel count and accumulator width.
- Adds atomic 64-bit tuning-word commit, programmable initial phase, common sync reload and per-channel wrap ticks.
- Sits behind the node's register bus, in the 125 MHz system domain, feeding DDS/demodulator logic.

Parameters:
- g_num_channels, 2, number of independent accumulators (1..8).
- g_acc_width, 48, accumulator/tuning-word width in bits (33..64).
- g_out_width, 16, phase bits exported per channel (MSBs of accumulator, 1..g_acc_width).

Ports:
- clk_sys_i  in  1  system clock, sole clock of the block.
- rst_a_i  in  1  asynchronous, active-high reset.
- reg_adr_i  in  8  byte address; channel = adr[6:4], register = adr[3:2].
- reg_dat_i  in  32  write data.
- reg_we_i  in  1  write enable, qualified by reg_stb_i.
- reg_stb_i  in  1  access strobe, single-cycle pulse.
- reg_dat_o  out  32  read data, valid with reg_ack_o.
- reg_ack_o  out  1  access acknowledge.
- sync_p_i  in  1  common sync pulse; reloads all enabled channels.
- phase_o  out  g_num_channels*g_out_width  accumulator MSBs; channel 0 in the LSBs.
- tick_o  out  g_num_channels  one-cycle pulse per channel on accumulator wrap.

Behaviour:
- Reset: all accumulators, FTW active/shadow, PHASE_INIT and CTRL = 0; phase_o = 0, tick_o = 0, reg_ack_o = 0, reg_dat_o = 0.
- Register map, per channel at ch*0x10:
  - 0x0 RFREQL: FTW shadow [31:0].
  - 0x4 RFREQH: FTW shadow [g_acc_width-1:32]; unused bits are ignored and read 0.
  - 0x8 PHASE_INIT: loaded into accumulator [g_acc_width-1:g_acc_width-32].
  - 0xC CTRL: bit0 ENABLE; bit1 SW_SYNC, write-1 self-clearing, reads 0.
- Bus:
  - reg_ack_o asserts exactly 1 cycle after reg_stb_i.
  - Reads return the shadow or register value.
  - Accesses to channel index >= g_num_channels are acked, writes are ignored, reads return 0.
  - Overlapping strobes are not supported; a strobe while ack is pending is ignored.
- FTW commit:
  - A write to RFREQH copies {new high, shadow low} into active FTW on the cycle the write is accepted.
  - The accumulator uses the new FTW from the following cycle.
  - A write to RFREQL alone never changes the active FTW.
- Accumulator:
  - When ENABLE=1: acc <= acc + ftw mod 2^g_acc_width, every cycle.
  - When ENABLE=0: acc holds its value.
  - Clearing ENABLE does not clear acc.
- Sync:
  - sync_p_i, or a SW_SYNC write, sets acc <= PHASE_INIT << (g_acc_width-32) on the next edge, for enabled channels only.
  - Sync has priority over increment in that cycle.
  - A simultaneous FTW commit is still accepted and applies from the cycle after.
- Outputs:
  - phase_o is registered from acc MSBs: 1 cycle latency after the acc update.
  - tick_o[ch] = registered carry-out of the add; no tick on a sync load.
- Reset mid-operation clears everything immediately (asynchronous); deassertion is assumed synchronised upstream.

Optional Feature:
- Macro: D3S_NCO_SNAPSHOT_EN.
- When defined:
  - Adds input snap_p_i.
  - On snap_p_i, all channels' acc[g_acc_width-1:g_acc_width-32] are captured together.
  - Captures are readable at 0x80+ch*4.
  - A new pulse overwrites the capture; capture regs reset to 0.
- When undefined: no port, and 0x80..0xFF reads return 0.

Decomposition:
- Package d3s_nco_pkg holds:
  - register offset constants (c_NCO_RFREQL=0x0, c_NCO_RFREQH=0x4, c_NCO_PHASE_INIT=0x8, c_NCO_CTRL=0xC);
  - CTRL bit indices;
  - a per-channel register record typedef.
- One sub-module, d3s_nco_channel: single accumulator with commit/sync/tick.
- The top instantiates it g_num_channels times and contains the bus decoder.

Test Plan:
- FTW commit: write RFREQL=0x10000000 only, with ENABLE=1 → phase_o frozen. Then write RFREQH=0 → acc advances 0x10000000/cycle, starting the cycle after the ack.
- Wrap tick (g_acc_width=48): FTW=0x4000_0000_0000 → tick_o[0] pulses every 4th cycle; phase_o[15:0] cycles 0x0000, 0x4000, 0x8000, 0xC000.
- Sync: PHASE_INIT=0x80000000, then pulse sync_p_i → next phase_o=0x8000, no tick. A disabled channel is unchanged.
- Simultaneous events: sync_p_i on the same edge as the RFREQH write → acc = init; the new FTW is applied the next cycle.
- Bus: read ch index 7 with g_num_channels=2 → ack after 1 cycle, data 0. CTRL read after SW_SYNC → bit1=0.
- Reset: assert rst_a_i mid-count → phase_o, tick_o and ack are 0 immediately. After release, all registers read 0.
